// File: rtl/multibank_ctrl.sv
// Multi-bank SRAM front end: decodes requests onto single-port bank macros, tags reads
// through the macro latency and returns read data in order through a credit-guarded FIFO.
module multibank_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned WMASK_WIDTH  = 4,
    parameter int unsigned BANK_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_we,
    input  logic [ADDR_WIDTH-1:0]                 req_addr,
    input  logic [DATA_WIDTH-1:0]                 req_wdata,
    input  logic [WMASK_WIDTH-1:0]                req_wmask,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_WIDTH-1:0]                 rsp_rdata,
    output logic [NUM_BANKS-1:0]                  bank_csb,
    output logic [NUM_BANKS-1:0]                  bank_web,
    output logic [ADDR_WIDTH-$clog2(NUM_BANKS)-1:0] bank_addr,
    output logic [DATA_WIDTH-1:0]                 bank_din,
    output logic [WMASK_WIDTH-1:0]                bank_wmask,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]       bank_dout
);

    localparam int unsigned BANK_SEL  = $clog2(NUM_BANKS);
    localparam int unsigned BIDX_W    = (BANK_SEL > 0) ? BANK_SEL : 1;
    localparam int unsigned BADDR_W   = ADDR_WIDTH - BANK_SEL;
    localparam int unsigned RSP_DEPTH = BANK_LATENCY + 2;
    localparam int unsigned IDX_W     = $clog2(RSP_DEPTH);
    localparam int unsigned PTR_W     = IDX_W + 1;
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);

    logic                                   w_acc;
    logic                                   w_rd_acc;
    logic                                   w_credit;
    logic                                   w_push;
    logic                                   w_pop;
    logic [BIDX_W-1:0]                      w_bank;
    logic [BADDR_W-1:0]                     w_baddr;
    logic [NUM_BANKS-1:0]                   w_onehot;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]   w_dout_arr;
    logic [DATA_WIDTH-1:0]                  w_dout;

    logic [NUM_BANKS-1:0]                   r_csb;
    logic [NUM_BANKS-1:0]                   r_web;
    logic [BADDR_W-1:0]                     r_addr;
    logic [DATA_WIDTH-1:0]                  r_din;
    logic [WMASK_WIDTH-1:0]                 r_wmask;
    logic [BANK_LATENCY:0]                  r_tag_v;
    logic [BANK_LATENCY:0][BIDX_W-1:0]      r_tag_b;
    logic [CNT_W-1:0]                       r_inflight;
    logic [CNT_W-1:0]                       r_count;
    logic [PTR_W-1:0]                       r_wr_ptr;
    logic [PTR_W-1:0]                       r_rd_ptr;
    logic [DATA_WIDTH-1:0]                  r_mem [RSP_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Bank decode from the top address bits; a single bank has no select field.
    if (BANK_SEL > 0) begin : g_dec
        assign w_bank  = req_addr[ADDR_WIDTH-1 -: BANK_SEL];
        assign w_baddr = req_addr[BADDR_W-1:0];
    end else begin : g_nodec
        assign w_bank  = '0;
        assign w_baddr = req_addr;
    end

    assign w_onehot   = NUM_BANKS'(1) << w_bank;
    assign w_credit   = (32'(r_inflight) + 32'(r_count)) < RSP_DEPTH;
    assign req_ready  = !rst && w_credit;
    assign w_acc      = req_valid && req_ready;
    assign w_rd_acc   = w_acc && !req_we;
    assign w_dout_arr = bank_dout;
    assign w_dout     = w_dout_arr[r_tag_b[BANK_LATENCY]];
    assign w_push     = r_tag_v[BANK_LATENCY];
    assign w_pop      = rsp_valid && rsp_ready;

    assign rsp_valid  = (r_count != '0);
    assign rsp_rdata  = r_mem[IDX_W'(r_rd_ptr)];
    assign bank_csb   = r_csb;
    assign bank_web   = r_web;
    assign bank_addr  = r_addr;
    assign bank_din   = r_din;
    assign bank_wmask = r_wmask;

    // Macro-side request registers; idle values whenever nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst || !w_acc) begin
            r_csb   <= '1;
            r_web   <= '1;
            r_addr  <= '0;
            r_din   <= '0;
            r_wmask <= '0;
        end else begin
            r_csb   <= ~w_onehot;
            r_web   <= req_we ? ~w_onehot : '1;
            r_addr  <= w_baddr;
            r_din   <= req_we ? req_wdata : '0;
            r_wmask <= req_we ? req_wmask : '0;
        end
    end

    // Read tags ride alongside the macro latency so the mux picks the bank that was read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            r_tag_b <= '0;
        end else begin
            r_tag_v <= {r_tag_v[BANK_LATENCY-1:0], w_rd_acc};
            r_tag_b <= {r_tag_b[BANK_LATENCY-1:0], w_bank};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case ({w_rd_acc, w_push})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
    end

    // Response storage; credit makes a push into a full FIFO unreachable.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[IDX_W'(r_wr_ptr)] <= w_dout;
        if (!rst) begin
            assert (!(w_push && !w_pop && r_count == CNT_W'(RSP_DEPTH)))
                else $error("multibank_ctrl: response FIFO overflow");
        end
    end

endmodule

// File: tb/tb_multibank_ctrl.sv
// Bench for multibank_ctrl: behavioural bank macros, a flat-memory transaction model with
// a response queue, a per-cycle compare process, and directed plus random stimulus.
module tb_multibank_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned NB    = 4;
    localparam int unsigned MW    = 4;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = LAT + 2;
    localparam int unsigned WPB   = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [MW-1:0]     req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic [NB-1:0]     bank_csb;
    logic [NB-1:0]     bank_web;
    logic [7:0]        bank_addr;
    logic [DW-1:0]     bank_din;
    logic [MW-1:0]     bank_wmask;
    logic [NB*DW-1:0]  bank_dout;

    multibank_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB),
        .WMASK_WIDTH(MW), .BANK_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .bank_csb(bank_csb), .bank_web(bank_web), .bank_addr(bank_addr),
        .bank_din(bank_din), .bank_wmask(bank_wmask), .bank_dout(bank_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    // Behavioural single-port bank macros, one-cycle read latency.
    logic [DW-1:0] bmem  [NB][WPB];
    logic [DW-1:0] bdout [NB];
    logic [DW-1:0] ref_mem [1024];

    initial begin
        for (int a = 0; a < 1024; a++) begin
            ref_mem[a]             = init_word(a);
            bmem[a / WPB][a % WPB] = init_word(a);
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!bank_csb[b]) begin
                if (!bank_web[b]) begin
                    for (int l = 0; l < MW; l++)
                        if (bank_wmask[l]) bmem[b][bank_addr][l*8 +: 8] = bank_din[l*8 +: 8];
                end else begin
                    bdout[b] <= bmem[b][bank_addr];
                end
            end
        end
    end

    assign bank_dout = {bdout[3], bdout[2], bdout[1], bdout[0]};

    // Transaction model: memory updated in acceptance order, reads queued with their due edge.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          q[$];
    logic          m_acc = 1'b0;
    logic          m_we  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] got[$];

    always @(posedge clk) begin
        bit vld_now;
        bit rdy_now;
        vld_now = (q.size() > 0) && (q[0].due <= edge_n);
        rdy_now = !rst && (q.size() < DEPTH);
        edge_n++;
        m_acc = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (vld_now && rsp_ready) void'(q.pop_front());
            if (req_valid && rdy_now) begin
                m_acc  = 1'b1;
                m_we   = req_we;
                m_addr = req_addr;
                if (req_we) begin
                    for (int l = 0; l < MW; l++)
                        if (req_wmask[l]) ref_mem[req_addr][l*8 +: 8] = req_wdata[l*8 +: 8];
                end else begin
                    q.push_back('{ref_mem[req_addr], edge_n + 2});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NB-1:0] e_csb;
        logic [NB-1:0] e_web;
        logic [7:0]    e_addr;
        logic          e_vld;
        int            b;
        b      = int'(m_addr) / WPB;
        e_csb  = m_acc ? (4'hF ^ (4'(1) << b)) : 4'hF;
        e_web  = (m_acc && m_we) ? e_csb : 4'hF;
        e_addr = m_acc ? 8'(int'(m_addr) % WPB) : 8'h00;
        e_vld  = (q.size() > 0) && (q[0].due <= edge_n);
        chk("req_ready", req_ready, !rst && (q.size() < DEPTH));
        chk("rsp_valid", rsp_valid, e_vld);
        if (e_vld) chk("rsp_rdata", rsp_rdata, q[0].data);
        chk("bank_csb", bank_csb, e_csb);
        chk("bank_web", bank_web, e_web);
        chk("bank_addr", bank_addr, e_addr);
        if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        idle();
        rsp_ready = 1'b1;
        repeat (8) step();
    endtask

    logic [AW-1:0] a4 [5] = '{10'h040, 10'h140, 10'h240, 10'h340, 10'h080};
    logic [AW-1:0] a5 [5] = '{10'h010, 10'h110, 10'h210, 10'h310, 10'h020};

    initial begin
        int n;
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;

        repeat (3) begin
            step();
            chk("rst_csb", bank_csb, 4'hF);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_req_ready", req_ready, 1'b0);
        end
        rst = 1'b0;
        step();
        chk("ready_after_rst", req_ready, 1'b1);

        // Writes to the first and last word, then read both back.
        send(1'b1, 10'h000, 32'hDEADBEEF, 4'hF); step();
        chk("wr0_csb", bank_csb, 4'b1110);
        send(1'b1, 10'h3FF, 32'h12345678, 4'hF); step();
        chk("wr3ff_csb", bank_csb, 4'b0111);
        send(1'b0, 10'h000, '0, '0); step();
        send(1'b0, 10'h3FF, '0, '0); step();
        idle(); step();
        chk("rd0_valid", rsp_valid, 1'b1);
        chk("rd0_data", rsp_rdata, 32'hDEADBEEF);
        step();
        chk("rd3ff_valid", rsp_valid, 1'b1);
        chk("rd3ff_data", rsp_rdata, 32'h12345678);
        drain();

        // Masked write merge, read immediately after the writes.
        send(1'b1, 10'h105, 32'h11223344, 4'hF); step();
        send(1'b1, 10'h105, 32'hAABBCCDD, 4'b0101); step();
        send(1'b0, 10'h105, '0, '0); step();
        idle(); step(); step();
        chk("mask_valid", rsp_valid, 1'b1);
        chk("mask_data", rsp_rdata, 32'h11BB33DD);
        drain();

        // Credit limit with a stalled consumer.
        rsp_ready = 1'b0; got.delete(); n = 0;
        for (int i = 0; i < 5; i++) begin
            if (n < 5) send(1'b0, a4[n], '0, '0);
            if (req_ready) n++;
            step();
        end
        chk("credit_accepts", n, 3);
        chk("credit_block", req_ready, 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && n < 5; i++) begin
            send(1'b0, a4[n], '0, '0);
            if (req_ready) n++;
            step();
        end
        chk("credit_all_accepted", n, 5);
        drain(); step(); step();
        chk("credit_rsp_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("credit_rsp_order", (i < got.size()) ? 64'(got[i]) : 'x, 64'(init_word(a4[i])));

        // Bank-rotating reads; the credit window allows a bubble but never a wrong bank.
        got.delete(); n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            send(1'b0, a5[n], '0, '0);
            if (req_ready) n++;
            step();
        end
        chk("rot_all_accepted", n, 5);
        drain();
        chk("rot_rsp_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rot_rsp_bank_data", (i < got.size()) ? 64'(got[i]) : 'x, 64'(init_word(a5[i])));

        // Reset with two reads in flight discards them.
        send(1'b0, 10'h010, '0, '0); step();
        send(1'b0, 10'h210, '0, '0); step();
        idle(); rst = 1'b1; step();
        rst = 1'b0;
        chk("post_rst_empty", rsp_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        chk("post_rst_ready", req_ready, 1'b1);

        // Random traffic over a few words per bank, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                send(1'($urandom_range(0, 1)),
                     {2'($urandom_range(0, 3)), 8'($urandom_range(0, 3))},
                     $urandom, 4'($urandom_range(0, 15)));
            else
                idle();
            step();
        end
        rst = 1'b0;
        drain();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
